pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Sequences stall, flush and redirect control for the 5-stage RV32I pipeline: IF, ID, EX, MEM, WB.
- Detects load-use hazards between ID and EX, squashes wrong-path instructions on EX-resolved branches and jumps, and freezes the pipeline while data memory is not ready.
- Sits beside the datapath and drives the enables and flushes of the PC and all pipeline registers.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- LOAD_USE_STALL, 1, stall cycles inserted per load-use hazard (legal 1..7).
- MEM_TIMEOUT, 64, consecutive memory-wait cycles after which mem_timeout is set (>=1).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_valid  in  1  EX holds a real (non-bubble) instruction.
- ex_is_load  in  1  EX instruction is LB/LH/LW/LBU/LHU.
- ex_rd  in  5  destination register of the EX instruction.
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR.
- mem_req  in  1  MEM stage has a valid load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- perf_clr  in  1  synchronous clear of the performance counters.
- pc_stall  out  1  hold the PC.
- pc_redirect  out  1  PC takes the EX target next edge.
- if_id_stall  out  1  hold the IF/ID register.
- if_id_flush  out  1  load a bubble into IF/ID.
- id_ex_flush  out  1  load a bubble into ID/EX.
- ex_mem_stall  out  1  hold ID/EX and EX/MEM.
- mem_wb_bubble  out  1  load a bubble into MEM/WB.
- stall_cycles  out  CNT_W  cycles with pc_stall=1, saturating.
- flush_events  out  CNT_W  count of pc_redirect pulses, saturating.
- mem_timeout  out  1  sticky; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, stall counter=0, wait counter=0.
  - stall_cycles, flush_events and mem_timeout are 0.
  - Every control output is 0 while rst_n=0.
  - Reset mid-stall abandons the stall; no residue remains after release.
- Control outputs are Mealy: combinational from the registered state and the current inputs.
- States: RUN, LOAD_STALL, MEM_WAIT. A ret_state register records the state MEM_WAIT returns to.
- Evaluation order: memstall, then redirect, then load-use.
- memstall = mem_req & ~mem_ready, evaluated in any state:
  - pc_stall, if_id_stall, ex_mem_stall and mem_wb_bubble are all 1; all flushes and pc_redirect are 0.
  - Entered from RUN or LOAD_STALL: ret_state <= current state; go MEM_WAIT.
  - The load-use stall counter is frozen.
  - ex_redirect is ignored: EX is held, so the redirect is re-presented after release.
- MEM_WAIT:
  - Wait counter increments each memstall cycle.
  - When the wait counter reaches MEM_TIMEOUT, mem_timeout <= 1.
  - When mem_ready=1 (or mem_req=0), go to ret_state and clear the wait counter. Outputs that cycle are those of ret_state evaluated with the current inputs.
- RUN, redirect (ex_redirect=1, no memstall):
  - pc_redirect=1, if_id_flush=1, id_ex_flush=1.
  - Load-use detection is suppressed because the ID instruction is wrong-path.
  - Stay in RUN.
- RUN, load-use:
  - Condition: ex_valid & ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Outputs: pc_stall=1, if_id_stall=1, id_ex_flush=1.
  - If LOAD_USE_STALL>1: counter <= LOAD_USE_STALL-1 and go LOAD_STALL. Otherwise stay in RUN.
- LOAD_STALL:
  - Outputs are the same as load-use.
  - Counter decrements each non-memstall cycle; go RUN when counter=1 decrements to 0.
  - Total stall is exactly LOAD_USE_STALL cycles, excluding memstall cycles.
  - ex_redirect is ignored (EX holds a bubble).
- If no hazard applies, all control outputs are 0.
- Counters:
  - stall_cycles increments when pc_stall=1; flush_events increments when pc_redirect=1.
  - Both saturate at all-ones.
  - perf_clr=1 zeroes both and has priority over increment in the same cycle.

Test Plan:
- Reset: rst_n=0 asserted mid-LOAD_STALL (LOAD_USE_STALL=3) -> all outputs 0 immediately; after release, state RUN and outputs 0 with idle inputs.
- Load-use: LW x5 in EX with ex_rd=5; ADD reads id_rs1=5 -> pc_stall=if_id_stall=id_ex_flush=1 for exactly LOAD_USE_STALL cycles (1 by default; 3 when LOAD_USE_STALL=3), stall_cycles increases by the same amount. Same case with ex_rd=0 -> no stall.
- Redirect: ex_redirect=1 with a coincident load-use match -> single cycle of pc_redirect=if_id_flush=id_ex_flush=1, pc_stall=0, flush_events +1.
- Memory wait: mem_req=1, mem_ready=0 for 5 cycles during LOAD_STALL with counter=2 -> full freeze for 5 cycles, then exactly 2 further load-use stall cycles; stall_cycles +7 over the sequence.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after the 4th wait cycle and stays 1 after mem_ready returns.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cycles=15; perf_clr together with a stall in the same cycle -> 0.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave): hazard inputs, stall/flush controls, perf status.
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_valid;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ready;
    logic             perf_clr;
    logic             pc_stall;
    logic             pc_redirect;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_stall;
    logic             mem_wb_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic             mem_timeout;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load,
               ex_rd, ex_redirect, mem_req, mem_ready, perf_clr,
        input  pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_flush,
               ex_mem_stall, mem_wb_bubble, stall_cycles, flush_events, mem_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load,
               ex_rd, ex_redirect, mem_req, mem_ready, perf_clr,
        output pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_flush,
               ex_mem_stall, mem_wb_bubble, stall_cycles, flush_events, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/redirect sequencer for the 5-stage RV32I pipeline, with
// saturating stall/flush performance counters and a sticky memory-timeout flag.
module pipeline_hazard_controller #(
    parameter int LOAD_USE_STALL = 1,
    parameter int MEM_TIMEOUT    = 64,
    parameter int CNT_W          = 32
) (
    input logic                         clk,
    input logic                         rst_n,
    pipeline_hazard_controller_if.slave hz
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

    state_t           state;
    state_t           ret_state;
    state_t           eff_state;
    logic [2:0]       stall_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic             mem_timeout_q;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_events_q;

    logic memstall;
    logic load_use;
    logic freeze;
    logic lu_stall;
    logic redirect;
    logic pc_stall_w;
    logic pc_redirect_w;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A cycle leaving MEM_WAIT behaves exactly like the state it returns to.
    always_comb begin
        memstall  = hz.mem_req & ~hz.mem_ready;
        eff_state = (state == MEM_WAIT) ? ret_state : state;
        load_use  = hz.ex_valid & hz.ex_is_load & (hz.ex_rd != 5'd0) &
                    ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
        freeze    = 1'b0;
        lu_stall  = 1'b0;
        redirect  = 1'b0;
        if (memstall) begin
            freeze = 1'b1;
        end else if (eff_state == LOAD_STALL) begin
            lu_stall = 1'b1;
        end else if (hz.ex_redirect) begin
            redirect = 1'b1;
        end else if (load_use) begin
            lu_stall = 1'b1;
        end
    end

    assign pc_stall_w       = rst_n & (freeze | lu_stall);
    assign pc_redirect_w    = rst_n & redirect;
    assign hz.pc_stall      = pc_stall_w;
    assign hz.pc_redirect   = pc_redirect_w;
    assign hz.if_id_stall   = rst_n & (freeze | lu_stall);
    assign hz.if_id_flush   = rst_n & redirect;
    assign hz.id_ex_flush   = rst_n & (redirect | lu_stall);
    assign hz.ex_mem_stall  = rst_n & freeze;
    assign hz.mem_wb_bubble = rst_n & freeze;
    assign hz.stall_cycles  = stall_cycles_q;
    assign hz.flush_events  = flush_events_q;
    assign hz.mem_timeout   = mem_timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ret_state <= RUN;
            stall_cnt <= '0;
            wait_cnt  <= '0;
        end else if (memstall) begin
            // The load-use counter is frozen while memory holds the pipe.
            if (state != MEM_WAIT) begin
                ret_state <= state;
            end
            state <= MEM_WAIT;
            if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end else begin
            wait_cnt <= '0;
            if (eff_state == LOAD_STALL) begin
                stall_cnt <= stall_cnt - 3'd1;
                state     <= (stall_cnt == 3'd1) ? RUN : LOAD_STALL;
            end else if (!hz.ex_redirect && load_use && (LOAD_USE_STALL > 1)) begin
                stall_cnt <= 3'(LOAD_USE_STALL - 1);
                state     <= LOAD_STALL;
            end else begin
                state <= RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_timeout_q <= 1'b0;
        end else if (memstall && (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1))) begin
            mem_timeout_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else if (hz.perf_clr) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (pc_stall_w) begin
                stall_cycles_q <= sat_inc(stall_cycles_q);
            end
            if (pc_redirect_w) begin
                flush_events_q <= sat_inc(flush_events_q);
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: a default instance and a (3,4,4) instance
// driven in lockstep, checked against a remaining-stall-cycles reference model.
`timescale 1ns/1ps
module tb_pipeline_hazard_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       exv;
        logic       exl;
        logic [4:0] rd;
        logic       redir;
        logic       req;
        logic       rdy;
        logic       clr;
    } stim_t;

    pipeline_hazard_controller_if #(.CNT_W(32)) ifa ();
    pipeline_hazard_controller_if #(.CNT_W(4))  ifb ();

    pipeline_hazard_controller dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa));
    pipeline_hazard_controller #(.LOAD_USE_STALL(3), .MEM_TIMEOUT(4), .CNT_W(4))
        dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb));

    // Control vector order: pc_stall, pc_redirect, if_id_stall, if_id_flush,
    // id_ex_flush, ex_mem_stall, mem_wb_bubble.
    logic [6:0]  ctl_obs [2];
    logic [31:0] sc_obs  [2];
    logic [31:0] fe_obs  [2];
    logic        to_obs  [2];
    assign ctl_obs[0] = {ifa.pc_stall, ifa.pc_redirect, ifa.if_id_stall, ifa.if_id_flush,
                         ifa.id_ex_flush, ifa.ex_mem_stall, ifa.mem_wb_bubble};
    assign ctl_obs[1] = {ifb.pc_stall, ifb.pc_redirect, ifb.if_id_stall, ifb.if_id_flush,
                         ifb.id_ex_flush, ifb.ex_mem_stall, ifb.mem_wb_bubble};
    assign sc_obs[0] = ifa.stall_cycles;
    assign sc_obs[1] = 32'(ifb.stall_cycles);
    assign fe_obs[0] = ifa.flush_events;
    assign fe_obs[1] = 32'(ifb.flush_events);
    assign to_obs[0] = ifa.mem_timeout;
    assign to_obs[1] = ifb.mem_timeout;

    int     lus  [2] = '{1, 3};
    int     mt   [2] = '{64, 4};
    longint cmax [2] = '{64'hFFFF_FFFF, 64'd15};
    int     pend [2];
    int     wrun [2];
    bit     tout [2];
    longint sc   [2];
    longint fe   [2];
    int     checks = 0;
    int     errors = 0;

    localparam logic [6:0] C_FREEZE = 7'b1010011;
    localparam logic [6:0] C_LOAD   = 7'b1010100;
    localparam logic [6:0] C_REDIR  = 7'b0101100;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(stim_t s);
        ifa.id_rs1 = s.rs1;       ifb.id_rs1 = s.rs1;
        ifa.id_rs2 = s.rs2;       ifb.id_rs2 = s.rs2;
        ifa.id_uses_rs1 = s.u1;   ifb.id_uses_rs1 = s.u1;
        ifa.id_uses_rs2 = s.u2;   ifb.id_uses_rs2 = s.u2;
        ifa.ex_valid = s.exv;     ifb.ex_valid = s.exv;
        ifa.ex_is_load = s.exl;   ifb.ex_is_load = s.exl;
        ifa.ex_rd = s.rd;         ifb.ex_rd = s.rd;
        ifa.ex_redirect = s.redir; ifb.ex_redirect = s.redir;
        ifa.mem_req = s.req;      ifb.mem_req = s.req;
        ifa.mem_ready = s.rdy;    ifb.mem_ready = s.rdy;
        ifa.perf_clr = s.clr;     ifb.perf_clr = s.clr;
    endtask

    function automatic bit is_lu(stim_t s);
        return s.exv && s.exl && (s.rd != 5'd0) &&
               ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    endfunction

    // Reference: a memory wait freezes everything; otherwise finish any owed
    // load-use stall cycles, then a redirect, then a fresh load-use hazard.
    function automatic logic [6:0] exp_ctrl(int k, stim_t s);
        if (s.req && !s.rdy) return C_FREEZE;
        if (pend[k] > 0)     return C_LOAD;
        if (s.redir)         return C_REDIR;
        if (is_lu(s))        return C_LOAD;
        return 7'b0;
    endfunction

    task automatic model_clock(int k, stim_t s, logic [6:0] ctl);
        if (s.req && !s.rdy) begin
            wrun[k]++;
            if (wrun[k] >= mt[k]) tout[k] = 1'b1;
        end else begin
            wrun[k] = 0;
            if (pend[k] > 0) pend[k]--;
            else if (!s.redir && is_lu(s)) pend[k] = lus[k] - 1;
        end
        if (s.clr) begin
            sc[k] = 0;
            fe[k] = 0;
        end else begin
            if (ctl[6] && sc[k] < cmax[k]) sc[k]++;
            if (ctl[5] && fe[k] < cmax[k]) fe[k]++;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0; wrun[k] = 0; tout[k] = 1'b0; sc[k] = 0; fe[k] = 0;
        end
    endtask

    task automatic step(stim_t s, string tag);
        logic [6:0] e [2];
        drive(s);
        #1;
        for (int k = 0; k < 2; k++) begin
            e[k] = exp_ctrl(k, s);
            chk($sformatf("%s/%0d ctl", tag, k), 32'(ctl_obs[k]), 32'(e[k]));
            chk($sformatf("%s/%0d stall_cycles", tag, k), sc_obs[k], 32'(sc[k]));
            chk($sformatf("%s/%0d flush_events", tag, k), fe_obs[k], 32'(fe[k]));
            chk($sformatf("%s/%0d mem_timeout", tag, k), 32'(to_obs[k]), 32'(tout[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_clock(k, s, e[k]);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s/%0d ctl", tag, k), 32'(ctl_obs[k]), 32'd0);
            chk($sformatf("%s/%0d stall_cycles", tag, k), sc_obs[k], 32'd0);
            chk($sformatf("%s/%0d flush_events", tag, k), fe_obs[k], 32'd0);
            chk($sformatf("%s/%0d mem_timeout", tag, k), 32'(to_obs[k]), 32'd0);
        end
    endtask

    initial begin
        stim_t idle, lu, bub, frz, rnd;
        idle = '0;
        lu = '0;
        lu.rs1 = 5'd5; lu.u1 = 1'b1; lu.exv = 1'b1; lu.exl = 1'b1; lu.rd = 5'd5; lu.rs2 = 5'd7;
        bub = idle; bub.rs1 = 5'd5; bub.u1 = 1'b1; bub.rd = 5'd5;
        frz = bub; frz.req = 1'b1;

        // Power-on reset
        drive(lu);
        @(negedge clk);
        #1;
        chk_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(idle, "idle0");
        step(idle, "idle1");

        // Load-use: LW x5 then ADD x?,x5 with a bubble following the load
        step(lu, "lu0");
        step(bub, "lu1");
        step(bub, "lu2");
        chk("lu_total/a", sc_obs[0], 32'd1);
        chk("lu_total/b", sc_obs[1], 32'd3);
        begin
            stim_t z;
            z = lu; z.rd = 5'd0; z.rs1 = 5'd0;
            step(z, "lu_rd0");
        end

        // Redirect wins over a coincident load-use match
        begin
            stim_t r;
            r = lu; r.redir = 1'b1;
            step(r, "redir");
        end
        step(idle, "post_redir");
        chk("redir_cnt/a", fe_obs[0], 32'd1);
        chk("redir_cnt/b", fe_obs[1], 32'd1);

        // Memory wait during LOAD_STALL (instance b counter at 2)
        step(lu, "mw_lu");
        for (int i = 0; i < 5; i++) step(frz, $sformatf("mw_frz%0d", i));
        step(bub, "mw_tail0");
        step(bub, "mw_tail1");
        step(idle, "mw_done");
        chk("mw_total/a", sc_obs[0], 32'd7);
        chk("mw_total/b", sc_obs[1], 32'd11);

        // Reset asserted mid-LOAD_STALL
        step(lu, "rst_lu");
        drive(lu);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(idle, "rst_rel0");
        step(bub, "rst_rel1");

        // Memory timeout (instance b: 4 wait cycles)
        for (int i = 0; i < 4; i++) step(frz, $sformatf("to_w%0d", i));
        chk("timeout/b", 32'(to_obs[1]), 32'd1);
        chk("timeout/a", 32'(to_obs[0]), 32'd0);
        begin
            stim_t rd;
            rd = frz; rd.rdy = 1'b1;
            step(rd, "to_ready");
        end
        step(idle, "to_idle");
        chk("timeout_sticky/b", 32'(to_obs[1]), 32'd1);

        // Counter saturation on the 4-bit instance, then clear beats increment
        for (int i = 0; i < 20; i++) step(lu, $sformatf("sat%0d", i));
        chk("sat/a", sc_obs[0], 32'd24);
        chk("sat/b", sc_obs[1], 32'd15);
        begin
            stim_t c;
            c = lu; c.clr = 1'b1;
            step(c, "clr");
        end
        chk("clr/a", sc_obs[0], 32'd0);
        chk("clr/b", sc_obs[1], 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rnd.rs1   = 5'($urandom_range(0, 3));
            rnd.rs2   = 5'($urandom_range(0, 3));
            rnd.u1    = 1'($urandom_range(0, 1));
            rnd.u2    = 1'($urandom_range(0, 1));
            rnd.exv   = ($urandom_range(0, 99) < 80);
            rnd.exl   = ($urandom_range(0, 99) < 50);
            rnd.rd    = 5'($urandom_range(0, 3));
            rnd.redir = ($urandom_range(0, 99) < 15);
            rnd.req   = ($urandom_range(0, 99) < 30);
            rnd.rdy   = ($urandom_range(0, 99) < 50);
            rnd.clr   = ($urandom_range(0, 99) < 3);
            step(rnd, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
